// File: rtl/segment_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : segment_display_arbiter
//  Purpose  : Round-robin sharing of the 8-digit seven-segment display
//             between NUM_REQ requesters, with a minimum hold per grant.
//             Drives number/switch of segment_switch.
//  Options  : SEG_ARB_PRIORITY_EN - requester 0 becomes preemptive.
//  Revision : 1.0 - initial release
// ============================================================================
module segment_display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   req_number,
    input  logic [NUM_REQ-1:0]      req_mode,
    output logic [NUM_REQ-1:0]      grant,
    output logic [31:0]             disp_number,
    output logic                    disp_switch,
    output logic                    disp_valid
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]         state, state_next;
    logic [PTR_W-1:0]   owner, owner_d;
    logic [PTR_W-1:0]   rr_ptr, rr_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [31:0]        number_d;
    logic               switch_d;
    logic               valid_d;

    logic [NUM_REQ-1:0] arb_req;
    logic [PTR_W-1:0]   arb_idx;
    logic               prio_pick;
    logic               do_grant;
    logic               do_clear;

    // Owner still asking, and whether anybody else is waiting
    logic               owner_req;
    logic [NUM_REQ-1:0] others;
    assign owner_req = |(req & grant);
    assign others    = req & ~grant;

    // Round-robin scan of arb_req starting at rr_ptr; requester 0 overrides when preemptive
    always_comb begin
        logic [PTR_W:0] pos;
        logic           found;
        found     = 1'b0;
        arb_idx   = '0;
        prio_pick = 1'b0;
        pos       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(NUM_REQ)) begin
                pos = pos - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && arb_req[pos[PTR_W-1:0]]) begin
                found   = 1'b1;
                arb_idx = pos[PTR_W-1:0];
            end
        end
`ifdef SEG_ARB_PRIORITY_EN
        if (req[0]) begin
            arb_idx   = '0;
            prio_pick = 1'b1;
        end
`endif
    end

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
            grant       <= '0;
            disp_number <= '0;
            disp_switch <= 1'b0;
            disp_valid  <= 1'b0;
        end else begin
            state       <= state_next;
            owner       <= owner_d;
            rr_ptr      <= rr_d;
            cnt         <= cnt_d;
            grant       <= grant_d;
            disp_number <= number_d;
            disp_switch <= switch_d;
            disp_valid  <= valid_d;
        end
    end

    // Next-state: decide between hold, release, rotation and preemption
    always_comb begin
        logic preempt;
        logic keep_prio;
        state_next = state;
        do_grant   = 1'b0;
        do_clear   = 1'b0;
        arb_req    = req;
        preempt    = 1'b0;
        keep_prio  = 1'b0;
`ifdef SEG_ARB_PRIORITY_EN
        preempt    = req[0] && (owner != '0);
        keep_prio  = req[0] && (owner == '0);
`endif
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    do_grant   = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!owner_req) begin
                    if (|req) begin
                        do_grant = 1'b1;
                    end else begin
                        do_clear   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (preempt) begin
                    do_grant = 1'b1;
                end else if ((cnt == CNT_MAX) && (|others) && !keep_prio) begin
                    // Owner sits out this round; the pointer is already past it
                    arb_req  = others;
                    do_grant = 1'b1;
                end
            end
            default: begin
                do_clear   = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values
    always_comb begin
        logic [PTR_W:0] inc;
        grant_d  = grant;
        owner_d  = owner;
        rr_d     = rr_ptr;
        cnt_d    = cnt;
        number_d = disp_number;
        switch_d = disp_switch;
        valid_d  = disp_valid;
        inc      = {1'b0, arb_idx} + (PTR_W+1)'(1);
        if (inc == (PTR_W+1)'(NUM_REQ)) begin
            inc = '0;
        end
        if (do_grant) begin
            grant_d          = '0;
            grant_d[arb_idx] = 1'b1;
            owner_d          = arb_idx;
            if (!prio_pick) begin
                rr_d = inc[PTR_W-1:0];
            end
            cnt_d    = '0;
            number_d = req_number[{arb_idx, 5'd0} +: 32];
            switch_d = req_mode[arb_idx];
            valid_d  = 1'b1;
        end else if (do_clear) begin
            grant_d  = '0;
            owner_d  = '0;
            cnt_d    = '0;
            number_d = '0;
            switch_d = 1'b0;
            valid_d  = 1'b0;
        end else if (state == ST_HOLD) begin
            number_d = req_number[{owner, 5'd0} +: 32];
            switch_d = req_mode[owner];
            if (cnt != CNT_MAX) begin
                cnt_d = cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_segment_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_segment_display_arbiter
//  Purpose  : Directed self-checking bench for segment_display_arbiter
//             (NUM_REQ=4, HOLD_CYCLES=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_segment_display_arbiter;

    logic         clk;
    logic         resetn;
    logic [3:0]   req;
    logic [127:0] req_number;
    logic [3:0]   req_mode;
    logic [3:0]   grant;
    logic [31:0]  disp_number;
    logic         disp_switch;
    logic         disp_valid;

    int total;
    int bad;

    segment_display_arbiter #(
        .NUM_REQ     (4),
        .HOLD_CYCLES (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .req_number  (req_number),
        .req_mode    (req_mode),
        .grant       (grant),
        .disp_number (disp_number),
        .disp_switch (disp_switch),
        .disp_valid  (disp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic [3:0]  rq;
        logic [3:0]  md;
        logic [31:0] n2;
        logic [3:0]  g;
        logic [31:0] num;
        logic        sw;
        logic        v;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nums(input logic [31:0] n0, input logic [31:0] n1,
                            input logic [31:0] n2, input logic [31:0] n3);
        req_number = {n3, n2, n1, n0};
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req    = 4'b0000;
        tick();
        resetn = 1'b1;
    endtask

    task automatic check_all(input string name, input logic [3:0] g, input logic [31:0] num,
                             input logic sw, input logic v);
        check({name, ".grant"}, 32'(grant), 32'(g));
        check({name, ".number"}, disp_number, num);
        check({name, ".switch"}, 32'(disp_switch), 32'(sw));
        check({name, ".valid"}, 32'(disp_valid), 32'(v));
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        resetn     = 1'b0;
        req        = 4'b0000;
        req_mode   = 4'b0000;
        req_number = '0;

        //            rstn  req      mode     n2            grant    number        sw    valid
        vt[0]  = '{1'b0, 4'b1111, 4'b0000, 32'h0000_1234, 4'b0000, 32'h0000_0000, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 4'b1111, 4'b0000, 32'h0000_1234, 4'b0000, 32'h0000_0000, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 4'b1111, 4'b0000, 32'h0000_1234, 4'b0001, 32'hC0DE_0000, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 4'b1111, 4'b0000, 32'h0000_1234, 4'b0000, 32'h0000_0000, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 4'b0100, 4'b0000, 32'h0000_1234, 4'b0100, 32'h0000_1234, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 4'b0100, 4'b0100, 32'h0000_5678, 4'b0100, 32'h0000_5678, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 4'b0000, 4'b0100, 32'h0000_5678, 4'b0000, 32'h0000_0000, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 4'b1000, 4'b1000, 32'h0000_5678, 4'b1000, 32'hC0DE_0003, 1'b1, 1'b1};
        vt[8]  = '{1'b1, 4'b1010, 4'b1000, 32'h0000_5678, 4'b1000, 32'hC0DE_0003, 1'b1, 1'b1};
        vt[9]  = '{1'b1, 4'b0010, 4'b1000, 32'h0000_5678, 4'b0010, 32'hC0DE_0001, 1'b0, 1'b1};
        vt[10] = '{1'b1, 4'b0000, 4'b1000, 32'h0000_5678, 4'b0000, 32'h0000_0000, 1'b0, 1'b0};

        // Table-driven: each vector is one clock edge
        for (int i = 0; i < 11; i++) begin
            resetn   = vt[i].rstn;
            req      = vt[i].rq;
            req_mode = vt[i].md;
            set_nums(32'hC0DE_0000, 32'hC0DE_0001, vt[i].n2, 32'hC0DE_0003);
            tick();
            check_all($sformatf("vec%0d", i), vt[i].g, vt[i].num, vt[i].sw, vt[i].v);
        end

        // Single requester keeps the display for a long time
        do_reset();
        req_mode = 4'b0000;
        set_nums(32'hC0DE_0000, 32'hC0DE_0001, 32'h0000_1234, 32'hC0DE_0003);
        req = 4'b0100;
        tick();
        check_all("solo_first", 4'b0100, 32'h0000_1234, 1'b0, 1'b1);
        for (int c = 0; c < 100; c++) begin
            tick();
            check($sformatf("solo_hold%0d", c), 32'(grant), 32'h4);
        end

        // All requesting: fair rotation, 8 cycles each, gapless
        do_reset();
        set_nums(32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            logic [3:0] eg;
            int         idx;
            idx = (c / 8) % 4;
            eg  = 4'b0001 << idx;
            tick();
            check($sformatf("rot_grant%0d", c), 32'(grant), 32'(eg));
            check($sformatf("rot_valid%0d", c), 32'(disp_valid), 32'h1);
            check($sformatf("rot_num%0d", c), disp_number, 32'hC0DE_0000 + 32'(idx));
        end

        // Owner 1 drops at count 3 with requester 3 waiting, then full release
        do_reset();
        req = 4'b0010;
        tick();
        check("drop_g0", 32'(grant), 32'h2);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("drop_hold%0d", c), 32'(grant), 32'h2);
        end
        req = 4'b1000;
        tick();
        check_all("drop_handover", 4'b1000, 32'hC0DE_0003, 1'b0, 1'b1);
        req = 4'b0000;
        tick();
        check_all("drop_idle", 4'b0000, 32'h0, 1'b0, 1'b0);

        // Owner value tracking with one cycle of lag, decimal mode
        do_reset();
        req_mode = 4'b0001;
        req      = 4'b0001;
        set_nums(32'd0, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
        tick();
        check_all("track0", 4'b0001, 32'd0, 1'b1, 1'b1);
        set_nums(32'd1, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
        tick();
        check("track1", disp_number, 32'd1);
        set_nums(32'd2, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
        tick();
        check("track2", disp_number, 32'd2);
        set_nums(32'd3, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
        #1;
        check("track_lag", disp_number, 32'd2);
        tick();
        check("track3", disp_number, 32'd3);
        check("track_sw", 32'(disp_switch), 32'h1);

        // Requester 0 arrives while owner 2 is at count 2
        do_reset();
        req_mode = 4'b0000;
        set_nums(32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
        req = 4'b0100;
        tick();
        tick();
        tick();
        check("prio_pre", 32'(grant), 32'h4);
        req = 4'b0101;
        tick();
`ifdef SEG_ARB_PRIORITY_EN
        check_all("prio_preempt", 4'b0001, 32'hC0DE_0000, 1'b0, 1'b1);
`else
        check("prio_wait3", 32'(grant), 32'h4);
        for (int c = 4; c <= 7; c++) begin
            tick();
            check($sformatf("prio_wait%0d", c), 32'(grant), 32'h4);
        end
        tick();
        check_all("prio_rotate", 4'b0001, 32'hC0DE_0000, 1'b0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
